// File: rtl/regfile_write_decode.sv
// 32-entry register file with one-hot write decode, two bypassed combinational
// read ports and a background scrub that clears r1..r31 one per cycle.
module regfile_write_decode #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              scrub_req,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [31:0]       wr_onehot,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic              busy_q;
  logic [31:0]       wr_onehot_q;
  logic [31:0]       wr_onehot_d;
  logic [31:0]       dec_s;
  logic              wr_commit_s;
  logic [DATA_W-1:0] regs_q [32];

  // Write qualification: r0 is never a target and writes are locked out while scrubbing.
  always_comb begin
    dec_s       = 32'd1 << wr_addr;
    wr_commit_s = 1'b0;
    wr_onehot_d = 32'd0;
    if (wr_en && !busy_q && (wr_addr != 5'd0)) begin
      wr_commit_s = 1'b1;
      wr_onehot_d = dec_s;
    end else begin
      wr_commit_s = 1'b0;
      wr_onehot_d = 32'd0;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if (wr_commit_s && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = regs_q[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    if (wr_commit_s && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = regs_q[rd_addr_b];
    end
  end

  // Scrub sequencer; cnt walks 1..31 so the scrub lasts exactly 31 edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      busy_q      <= 1'b0;
      wr_onehot_q <= 32'd0;
    end else begin
      wr_onehot_q <= wr_onehot_d;
      case (state_q)
        IDLE: begin
          if (scrub_req) begin
            state_q <= SCRUB;
            cnt_q   <= 5'd1;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
          end
        end
        SCRUB: begin
          if (cnt_q == 5'd31) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 5'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 5'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: r0 is cleared by reset and never addressed by either write source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (busy_q) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_commit_s) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign wr_onehot = wr_onehot_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_write_decode.sv
// Directed and randomized bench for regfile_write_decode, checked against an
// array-based model of the register file and a scrub progress counter.
module tb_regfile_write_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        scrub_req;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] wr_onehot;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: register contents plus how many edges of a scrub have elapsed (0 = idle).
  logic [31:0] m_regs [32];
  int          m_scrub_edges;
  logic [31:0] m_onehot;

  regfile_write_decode #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .scrub_req(scrub_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wr_onehot(wr_onehot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_scrub_edges = 0;
    m_onehot      = 32'd0;
  endtask

  task automatic set_in(input logic en, input logic [4:0] a, input logic [31:0] d,
                        input logic s, input logic [4:0] ra, input logic [4:0] rb);
    wr_en = en; wr_addr = a; wr_data = d; scrub_req = s; rd_addr_a = ra; rd_addr_b = rb;
  endtask

  // One clock: check reads mid-cycle, advance the model at the edge, then check registered outputs.
  task automatic cycle();
    logic        wr_ok;
    logic [31:0] exp_a, exp_b;
    #1;
    wr_ok = wr_en && (m_scrub_edges == 0) && (wr_addr != 5'd0);
    exp_a = (wr_ok && wr_addr == rd_addr_a) ? wr_data : m_regs[rd_addr_a];
    exp_b = (wr_ok && wr_addr == rd_addr_b) ? wr_data : m_regs[rd_addr_b];
    chk("rd_a", rd_data_a, exp_a);
    chk("rd_b", rd_data_b, exp_b);
    @(posedge clk);
    if (m_scrub_edges != 0) begin
      // During the k-th scrub edge register k is cleared; the 31st edge ends the scrub.
      m_regs[m_scrub_edges] = 32'd0;
      m_onehot = 32'd0;
      m_scrub_edges = (m_scrub_edges == 31) ? 0 : m_scrub_edges + 1;
    end else begin
      if (wr_ok) begin
        m_regs[wr_addr] = wr_data;
        m_onehot = 32'd1 << wr_addr;
      end else begin
        m_onehot = 32'd0;
      end
      if (scrub_req) m_scrub_edges = 1;
    end
    #1;
    chk("onehot", wr_onehot, m_onehot);
    chk("busy", {31'd0, busy}, {31'd0, m_scrub_edges != 0});
  endtask

  task automatic fill_all();
    for (int i = 1; i < 32; i++) begin
      set_in(1'b1, 5'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 1'b0, 5'(i), 5'(32 - i));
      cycle();
    end
  endtask

  initial begin
    int busy_cycles;
    model_clear();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    reset = 1'b1;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_onehot", wr_onehot, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Write r5 and read it back the following cycle.
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd1, 5'd2);
    cycle();
    chk("r5_onehot", wr_onehot, 32'h0000_0020);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd5);
    cycle();
    chk("r5_read", rd_data_a, 32'hDEADBEEF);
    chk("r5_onehot_clr", wr_onehot, 32'd0);

    // Writes to r0 are discarded.
    set_in(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd5, 5'd0);
    #1;
    chk("r0_same_cycle", rd_data_b, 32'd0);
    cycle();
    chk("r0_onehot", wr_onehot, 32'd0);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    cycle();
    chk("r0_after", rd_data_b, 32'd0);

    // Same-cycle bypass.
    set_in(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd7, 5'd5);
    #1;
    chk("bypass_r7", rd_data_a, 32'h12345678);
    cycle();

    // Full scrub with writes attempted throughout.
    fill_all();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 5'd1);
    cycle();
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      set_in(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1,
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle();
    end
    chk("scrub_len", 32'(busy_cycles), 32'd31);
    for (int i = 0; i < 32; i += 2) begin
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'(i), 5'(i + 1));
      #1;
      chk("post_scrub_a", rd_data_a, 32'd0);
      chk("post_scrub_b", rd_data_b, 32'd0);
      cycle();
    end

    // Reset ten cycles into a scrub.
    fill_all();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd20, 5'd30);
      cycle();
    end
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 32; i += 2) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(i + 1);
      #1;
      chk("abort_rd_a", rd_data_a, 32'd0);
      chk("abort_rd_b", rd_data_b, 32'd0);
    end
    set_in(1'b1, 5'd3, 32'hCAFEF00D, 1'b1, 5'd4, 5'd4);
    @(posedge clk);
    #1;
    chk("rst_no_onehot", wr_onehot, 32'd0);
    chk("rst_no_scrub", {31'd0, busy}, 32'd0);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd3);
    #1;
    chk("rst_no_write", rd_data_a, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    set_in(1'b1, 5'd3, 32'h0BADF00D, 1'b0, 5'd0, 5'd0);
    cycle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd0);
    cycle();
    chk("r3_after_rst", rd_data_a, 32'h0BADF00D);

    // Write and scrub request together.
    set_in(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd3);
    cycle();
    chk("r9_onehot", wr_onehot, 32'h0000_0200);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd3);
    #1;
    chk("r9_stored", rd_data_a, 32'hA5A5A5A5);
    for (int i = 0; i < 31; i++) begin
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd3);
      cycle();
    end
    chk("r9_cleared", rd_data_a, 32'd0);

    // Randomized traffic with occasional scrubs.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
             ($urandom_range(0, 59) == 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
